// File: rtl/vin_quadrature_counter.sv
// vin_quadrature_counter: filtered A/B/Z quadrature decoder; index latch enabled by VIN_QUADRATURE_INDEX_EN.
module vin_quadrature_counter #(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        QUAD_A,
  input  logic                        QUAD_B,
  input  logic                        QUAD_Z,
  input  logic                        indexEnable,
  input  logic                        errorClear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [POS_WIDTH-1:0] indexPosition,
  output logic                        indexDone,
  output logic                        quadError
);
`ifdef VIN_QUADRATURE_INDEX_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam logic [7:0] LAST = 8'(FILTER_CYCLES - 1);
  logic [N-1:0] pins, s1, s2, filt, filt_d, filt_nx;
  logic [7:0] cnt [N];
  logic [7:0] cnt_nx [N];
  logic [1:0] d;
  logic [POS_WIDTH-1:0] next_pos;
`ifdef VIN_QUADRATURE_INDEX_EN
  assign pins = {QUAD_Z, QUAD_B, QUAD_A};
`else
  logic unused_in;
  assign unused_in = ^{QUAD_Z, indexEnable};
  assign pins = {QUAD_B, QUAD_A};
`endif
  always_comb begin
    filt_nx = filt;
    cnt_nx = cnt;
    for (int i = 0; i < N; i++) begin
      cnt_nx[i] = (s2[i] == filt[i] || cnt[i] == LAST) ? 8'd0 : cnt[i] + 8'd1;
      filt_nx[i] = (s2[i] != filt[i] && cnt[i] == LAST) ? s2[i] : filt[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      filt_d <= '0;
      cnt <= '{default: 8'd0};
    end else begin
      s1 <= pins;
      s2 <= s1;
      filt <= filt_nx;
      filt_d <= filt;
      cnt <= cnt_nx;
    end
  end
  // Gray phase {B, A^B} counts 0,1,2,3 along the forward sequence
  assign d = {filt[1], filt[1] ^ filt[0]} - {filt_d[1], filt_d[1] ^ filt_d[0]};
  assign next_pos = d == 2'd1 ? position + POS_WIDTH'(1) :
                    d == 2'd3 ? position - POS_WIDTH'(1) : position;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) quadError <= 1'b0;
    else if (d == 2'd2) quadError <= 1'b1;
    else if (errorClear) quadError <= 1'b0;
  end
`ifdef VIN_QUADRATURE_INDEX_EN
  logic en_d, armed, ev;
  assign ev = armed & indexEnable & filt[2] & ~filt_d[2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position <= '0;
      indexPosition <= '0;
      indexDone <= 1'b0;
      armed <= 1'b0;
      en_d <= 1'b0;
    end else begin
      en_d <= indexEnable;
      position <= ev ? '0 : next_pos;
      if (ev) indexPosition <= next_pos;
      armed <= indexEnable & ~ev & (armed | (~en_d & ~indexDone));
      indexDone <= indexEnable & (indexDone | ev);
    end
  end
`else
  assign indexPosition = '0;
  assign indexDone = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) position <= '0;
    else position <= next_pos;
  end
`endif
endmodule
